// File: rtl/apb_protocol_slave_if.sv
// APB link between one master and one completer; the completer drives the response group.
interface apb_protocol_slave_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_protocol_slave.sv
// APB completer: DEPTH-entry register file with WAIT_CYCLES wait states and range-checked pslverr.
// Optional APB_SLV_RO_STATUS_EN turns the top register into a read-only count of completed writes.
module apb_protocol_slave #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input logic                 pclk,
  input logic                 presetn,
  apb_protocol_slave_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DEPTH_U = DEPTH;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic [IDX_W-1:0]  addr_q;
  logic              wr_q;
  logic              err_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rdy_q;
  logic              slverr_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic              setup_err;

  // Index bits are only used to read/write the array once the range check has passed.
  assign idx = bus.paddr[IDX_W-1:0];

  always_comb begin
    setup_err = (32'(bus.paddr) >= DEPTH_U);
`ifdef APB_SLV_RO_STATUS_EN
    if (bus.pwrite && (32'(bus.paddr) == DEPTH_U - 1)) setup_err = 1'b1;
`endif
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state    <= S_IDLE;
      cnt      <= '0;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      rdy_q    <= 1'b0;
      slverr_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Access phase without a preceding setup is ignored.
          if (bus.psel && !bus.penable) begin
            addr_q  <= idx;
            wr_q    <= bus.pwrite;
            wdata_q <= bus.pwdata;
            err_q   <= setup_err;
            if (WAIT_CYCLES == 0) begin
              state    <= S_DONE;
              rdy_q    <= 1'b1;
              slverr_q <= setup_err;
              if (!bus.pwrite) rdata_q <= setup_err ? '0 : mem[idx];
            end else begin
              cnt   <= 4'(WAIT_CYCLES);
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (!bus.psel) begin
            state <= S_IDLE;
            cnt   <= '0;
          end else if (bus.penable) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state    <= S_DONE;
              rdy_q    <= 1'b1;
              slverr_q <= err_q;
              if (!wr_q) rdata_q <= err_q ? '0 : mem[addr_q];
            end
          end
        end
        S_DONE: begin
          if (!bus.psel) begin
            state    <= S_IDLE;
            rdy_q    <= 1'b0;
            slverr_q <= 1'b0;
          end else if (bus.penable) begin
            if (wr_q && !err_q) begin
              mem[addr_q] <= wdata_q;
`ifdef APB_SLV_RO_STATUS_EN
              // Writes to the status slot are flagged as errors, so this never collides.
              mem[DEPTH-1] <= mem[DEPTH-1] + 1'b1;
`endif
            end
            state    <= S_IDLE;
            rdy_q    <= 1'b0;
            slverr_q <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          rdy_q    <= 1'b0;
          slverr_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.prdata  = rdata_q;
  assign bus.pready  = rdy_q;
  assign bus.pslverr = slverr_q;
endmodule

// File: tb/tb_apb_protocol_slave.sv
// Scoreboard bench: three completers with 0, 1 and 3 wait states driven by one APB master model.
module tb_apb_protocol_slave;
  localparam int NDUT = 3;

  logic pclk = 1'b0;
  logic presetn = 1'b0;
  always #5 pclk = ~pclk;

  logic [NDUT-1:0] psel = '0;
  logic            penable = 1'b0;
  logic            pwrite = 1'b0;
  logic [7:0]      paddr = '0;
  logic [7:0]      pwdata = '0;
  logic [NDUT-1:0] pready;
  logic [NDUT-1:0] pslverr;
  logic [7:0]      prdata [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int W = (g == 0) ? 0 : (g == 1) ? 1 : 3;
    apb_protocol_slave_if #(.ADDR_W(8), .DATA_W(8)) bus ();
    assign bus.psel    = psel[g];
    assign bus.penable = penable;
    assign bus.pwrite  = pwrite;
    assign bus.paddr   = paddr;
    assign bus.pwdata  = pwdata;
    assign pready[g]   = bus.pready;
    assign pslverr[g]  = bus.pslverr;
    assign prdata[g]   = bus.prdata;
    apb_protocol_slave #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(W)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus)
    );
  end

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    logic       rd;
    int         cyc;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model [NDUT][16];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int wfor(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  function automatic logic exp_err(input logic wr, input logic [7:0] a);
    logic e;
    e = (a >= 8'd16);
`ifdef APB_SLV_RO_STATUS_EN
    if (wr && a == 8'd15) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic void model_clear();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 16; i++) model[d][i] = 8'h00;
  endfunction

  task automatic idle();
    psel = '0;
    penable = 1'b0;
    @(negedge pclk);
  endtask

  // Starts at a falling edge; returns at the falling edge after the completion edge.
  task automatic xfer(input int d, input logic wr, input logic [7:0] a, input logic [7:0] dat);
    exp_t e;
    exp_t got;
    int   cyc;
    e.err   = exp_err(wr, a);
    e.rd    = !wr;
    e.rdata = e.err ? 8'h00 : model[d][a[3:0]];
    e.cyc   = wfor(d) + 1;
    sb.push_back(e);
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = dat;
    @(negedge pclk);
    penable = 1'b1;
    cyc = 1;
    while (!pready[d] && cyc < 20) begin
      @(negedge pclk);
      cyc++;
    end
    got = sb.pop_front();
    check($sformatf("cyc_d%0d_a%0h", d, a), cyc, got.cyc);
    check($sformatf("slverr_d%0d_a%0h", d, a), {31'd0, pslverr[d]}, {31'd0, got.err});
    if (got.rd) check($sformatf("rdata_d%0d_a%0h", d, a), {24'd0, prdata[d]}, {24'd0, got.rdata});
    @(negedge pclk);
    check($sformatf("rdy_clr_d%0d", d), {30'd0, pready[d], pslverr[d]}, 32'd0);
    if (wr && !got.err) begin
      model[d][a[3:0]] = dat;
`ifdef APB_SLV_RO_STATUS_EN
      model[d][15] = model[d][15] + 8'd1;
`endif
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    #1;
    for (int d = 0; d < NDUT; d++)
      check($sformatf("rst_d%0d", d), {23'd0, pready[d], pslverr[d], prdata[d]}, 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);

    // Reset in the middle of a wait state.
    xfer(1, 1'b1, 8'h02, 8'h3C);
    xfer(1, 1'b0, 8'h02, 8'h00);
    psel = 3'b010; penable = 1'b0; pwrite = 1'b0; paddr = 8'h02;
    @(negedge pclk);
    penable = 1'b1;
    #2 presetn = 1'b0;
    #1 check("rst_mid", {23'd0, pready[1], pslverr[1], prdata[1]}, 32'd0);
    psel = '0; penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    model_clear();
    @(negedge pclk);
    xfer(1, 1'b0, 8'h02, 8'h00);
    idle();

    // One wait state: write then read.
    xfer(1, 1'b1, 8'h03, 8'hA5);
    xfer(1, 1'b0, 8'h03, 8'h00);
    xfer(1, 1'b1, 8'h09, 8'h6E);
    check("rdata_hold", {24'd0, prdata[1]}, 32'h0000_00A5);
    idle();

    // Zero wait states, back-to-back.
    xfer(0, 1'b1, 8'h00, 8'h11);
    xfer(0, 1'b1, 8'h01, 8'h22);
    xfer(0, 1'b0, 8'h00, 8'h00);
    xfer(0, 1'b0, 8'h01, 8'h00);
    xfer(0, 1'b0, 8'h20, 8'h00);
    idle();

    // Out of range, then scan the whole file for collateral damage.
    xfer(1, 1'b1, 8'h10, 8'h5A);
    xfer(1, 1'b0, 8'h10, 8'h00);
    xfer(1, 1'b1, 8'hFF, 8'h5A);
    for (int a = 0; a < 16; a++) xfer(1, 1'b0, 8'(a), 8'h00);
    idle();

    // Abort a three-wait-state write after one access cycle.
    xfer(2, 1'b1, 8'h04, 8'h33);
    psel = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 8'h77;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    check("abort_rdy0", {31'd0, pready[2]}, 32'd0);
    psel = '0; penable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      check($sformatf("abort_quiet%0d", i), {30'd0, pready[2], pslverr[2]}, 32'd0);
    end
    xfer(2, 1'b0, 8'h04, 8'h00);
    xfer(2, 1'b1, 8'h05, 8'h44);
    xfer(2, 1'b0, 8'h05, 8'h00);
    idle();

    // Top register: read-only status counter when the option is built in.
    xfer(1, 1'b1, 8'h02, 8'hC1);
    xfer(1, 1'b1, 8'h06, 8'hC2);
    xfer(1, 1'b1, 8'h07, 8'hC3);
    xfer(1, 1'b1, 8'h0F, 8'h99);
    xfer(1, 1'b0, 8'h0F, 8'h00);
    xfer(1, 1'b0, 8'h07, 8'h00);
    idle();
    check("sb_empty", sb.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
